// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings and the transmit-arbiter state enum.
package uart_pkg;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_ODD  = 2'd1;
  localparam logic [1:0] PARITY_EVEN = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: searches req starting at last+1 (mod NUM_REQ)
// and reports the first set requester.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  // Scan farthest-first so the requester closest after last is the final assignment.
  always_comb begin
    int c;
    logic [IDX_W-1:0] idx;
    winner = '0;
    valid  = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      c = int'(last) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      idx = IDX_W'(c);
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Optional per-byte watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [2*NUM_REQ-1:0] req_parity,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic [7:0]           tx_data,
  output logic [1:0]           tx_parity_type,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic                 busy,
  output logic                 timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t       state, state_next;
  logic [IDX_W-1:0] last, owner, pick;
  logic             pick_vld;
  logic             load, finish, abort;
  logic             wd_hit;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    return NUM_REQ'(1) << i;
  endfunction

  uart_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (req),
    .last   (last),
    .winner (pick),
    .valid  (pick_vld)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt;

  // Counter is cleared outside the two wait states, so it measures time since START.
  assign wd_hit = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || state == IDLE || state == START) wd_cnt <= '0;
    else                                         wd_cnt <= wd_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) timeout <= 1'b0;
    else     timeout <= abort;
  end
`else
  assign wd_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next = state;
    load       = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          load       = 1'b1;
          state_next = START;
        end
      end
      START: state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (wd_hit) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (tx_busy) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // A genuine completion in the same cycle as the watchdog still counts as done.
        if (!tx_busy) begin
          finish     = 1'b1;
          state_next = IDLE;
        end else if (wd_hit) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      last           <= IDX_W'(NUM_REQ - 1);
      owner          <= '0;
      grant          <= '0;
      done           <= '0;
      tx_start       <= 1'b0;
      tx_data        <= '0;
      tx_parity_type <= PARITY_NONE;
    end else begin
      state    <= state_next;
      tx_start <= load;
      grant    <= load ? onehot(pick) : '0;
      done     <= finish ? onehot(owner) : '0;
      if (load) begin
        owner          <= pick;
        tx_data        <= req_data[int'(pick)*8 +: 8];
        tx_parity_type <= req_parity[int'(pick)*2 +: 2];
      end
      if (finish || abort) last <= owner;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a simple transmitter busy model.
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int K_GRANT = 0;
  localparam int K_DONE  = 1;
  localparam int K_TO    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [2*NREQ-1:0] req_parity = '0;
  logic              tx_busy = 1'b0;
  logic [NREQ-1:0]   grant, done;
  logic [7:0]        tx_data;
  logic [1:0]        tx_parity_type;
  logic              tx_start, busy, timeout;

  typedef struct {
    int         kind;
    int         idx;
    logic [7:0] data;
    logic [1:0] par;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] held_data = '0;
  logic [1:0] held_par = '0;
  bit         model_en = 1'b1;

  uart_tx_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(50)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_data       (req_data),
    .req_parity     (req_parity),
    .grant          (grant),
    .done           (done),
    .tx_data        (tx_data),
    .tx_parity_type (tx_parity_type),
    .tx_start       (tx_start),
    .tx_busy        (tx_busy),
    .busy           (busy),
    .timeout        (timeout)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic push(input int kind, input int idx, input logic [7:0] d, input logic [1:0] p);
    exp_t e;
    e.kind = kind; e.idx = idx; e.data = d; e.par = p;
    q.push_back(e);
  endtask

  task automatic set_src(input int i, input logic [7:0] d, input logic [1:0] p);
    req_data[8*i +: 8]   = d;
    req_parity[2*i +: 2] = p;
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (grant == '0 && n < 100);
    if (grant == '0) chk(name, 32'd0, 32'd1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (done == '0 && n < 100);
    if (done == '0) chk(name, 32'd0, 32'd1);
  endtask

  task automatic pulse_reset(input string name);
    rst = 1'b1;
    @(negedge clk);
    chk(name, {grant, done, tx_data, tx_parity_type, tx_start, busy, timeout}, 32'd0);
    rst = 1'b0;
  endtask

  // Transmitter model: busy rises two cycles after start and lasts ten bit-times.
  initial forever begin
    @(negedge clk);
    if (tx_start && model_en) begin
      repeat (2) @(negedge clk);
      tx_busy = 1'b1;
      repeat (10) @(negedge clk);
      tx_busy = 1'b0;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents grant, done or timeout.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      chk("grant_onehot", 32'($onehot0(grant)), 32'd1);
      chk("done_onehot", 32'($onehot0(done)), 32'd1);
      if (grant != '0) begin
        if (q.size() == 0) chk("unexpected_grant", 32'(grant), 32'd0);
        else begin
          e = q.pop_front();
          chk("grant_kind", e.kind, K_GRANT);
          chk("grant_mask", 32'(grant), 32'(NREQ'(1) << e.idx));
          chk("grant_data", 32'(tx_data), 32'(e.data));
          chk("grant_parity", 32'(tx_parity_type), 32'(e.par));
          chk("grant_start", 32'(tx_start), 32'd1);
        end
        held_data = tx_data;
        held_par  = tx_parity_type;
      end else begin
        if (tx_start) chk("stray_start", 32'd1, 32'd0);
        if (busy) chk("data_hold", {tx_parity_type, tx_data}, {held_par, held_data});
      end
      if (done != '0) begin
        if (q.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
        else begin
          e = q.pop_front();
          chk("done_kind", e.kind, K_DONE);
          chk("done_mask", 32'(done), 32'(NREQ'(1) << e.idx));
        end
      end
      if (timeout) begin
        if (q.size() == 0) chk("unexpected_timeout", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("timeout_kind", e.kind, K_TO);
          chk("timeout_busy", 32'(busy), 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs", {grant, done, tx_data, tx_parity_type, tx_start, busy, timeout}, 32'd0);
    rst = 1'b0;

    // Single byte from requester 0.
    set_src(0, 8'hA5, 2'd0);
    push(K_GRANT, 0, 8'hA5, 2'd0);
    push(K_DONE, 0, 8'h00, 2'd0);
    req = 4'b0001;
    wait_grant("single_grant");
    req = '0;
    wait_done("single_done");

    // All four requesting: rotation 0,1,2,3,0 from reset.
    pulse_reset("reset_before_rr");
    set_src(0, 8'h11, 2'd1);
    set_src(1, 8'h22, 2'd2);
    set_src(2, 8'h33, 2'd0);
    set_src(3, 8'h44, 2'd3);
    push(K_GRANT, 0, 8'h11, 2'd1); push(K_DONE, 0, 8'h00, 2'd0);
    push(K_GRANT, 1, 8'h22, 2'd2); push(K_DONE, 1, 8'h00, 2'd0);
    push(K_GRANT, 2, 8'h33, 2'd0); push(K_DONE, 2, 8'h00, 2'd0);
    push(K_GRANT, 3, 8'h44, 2'd3); push(K_DONE, 3, 8'h00, 2'd0);
    push(K_GRANT, 0, 8'h11, 2'd1); push(K_DONE, 0, 8'h00, 2'd0);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) wait_done("rr_done");
    req = '0;

    // Withdrawn request from 2 is never served; requester 1 is served next.
    set_src(0, 8'h5A, 2'd2);
    set_src(1, 8'hC3, 2'd1);
    push(K_GRANT, 0, 8'h5A, 2'd2); push(K_DONE, 0, 8'h00, 2'd0);
    push(K_GRANT, 1, 8'hC3, 2'd1); push(K_DONE, 1, 8'h00, 2'd0);
    req = 4'b0001;
    wait_grant("withdraw_grant0");
    req = '0;
    repeat (3) @(negedge clk);
    req = 4'b0100;
    repeat (3) @(negedge clk);
    req = 4'b0010;
    wait_grant("withdraw_grant1");
    req = '0;
    wait_done("withdraw_done1");

    // Even parity byte held stable while the source changes underneath.
    set_src(2, 8'hAB, 2'd2);
    push(K_GRANT, 2, 8'hAB, 2'd2); push(K_DONE, 2, 8'h00, 2'd0);
    req = 4'b0100;
    wait_grant("hold_grant");
    req = '0;
    set_src(2, 8'h00, 2'd1);
    wait_done("hold_done");

    // Reset in WAIT_DONE after requester 0 was last served.
    set_src(0, 8'h01, 2'd0);
    set_src(1, 8'h02, 2'd0);
    push(K_GRANT, 0, 8'h01, 2'd0); push(K_DONE, 0, 8'h00, 2'd0);
    req = 4'b0001;
    wait_grant("pre_reset_grant0");
    req = '0;
    wait_done("pre_reset_done0");
    push(K_GRANT, 1, 8'h02, 2'd0);
    req = 4'b0010;
    wait_grant("pre_reset_grant1");
    req = '0;
    repeat (5) @(negedge clk);
    pulse_reset("reset_mid_transfer");
    repeat (15) @(negedge clk);
    push(K_GRANT, 0, 8'h01, 2'd0); push(K_DONE, 0, 8'h00, 2'd0);
    req = 4'b0011;
    wait_grant("post_reset_grant");
    req = '0;
    wait_done("post_reset_done");

    // Transmitter stuck busy.
    model_en = 1'b0;
    set_src(0, 8'h77, 2'd1);
    push(K_GRANT, 0, 8'h77, 2'd1);
`ifdef UART_ARB_TIMEOUT_EN
    push(K_TO, 0, 8'h00, 2'd0);
    req = 4'b0001;
    wait_grant("stuck_grant");
    req = '0;
    tx_busy = 1'b1;
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!timeout && n < 200);
      chk("timeout_latency", n, 51);
    end
    tx_busy = 1'b0;
    repeat (3) @(negedge clk);
`else
    push(K_DONE, 0, 8'h00, 2'd0);
    req = 4'b0001;
    wait_grant("stuck_grant");
    req = '0;
    tx_busy = 1'b1;
    repeat (60) @(negedge clk);
    chk("stuck_busy", 32'(busy), 32'd1);
    chk("stuck_no_timeout", 32'(timeout), 32'd0);
    tx_busy = 1'b0;
    wait_done("stuck_release_done");
`endif
    model_en = 1'b1;

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
